// File: rtl/ghostbus_pkg.sv
// Shared constants for the ghostbus host: default bus widths, FSM state codes
// and the read-latency ceiling.
package ghostbus_pkg;

    localparam int GB_AW      = 12;
    localparam int GB_DW      = 32;
    localparam int RD_LAT_MAX = 15;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RSP     = 3'd4;

endpackage

// File: rtl/ghostbus_rd_timer.sv
// Loadable down-counter with a registered done flag (count == 0); load wins
// over decrement and the counter never wraps below zero.
module ghostbus_rd_timer
    import ghostbus_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count_q, count_d;
    logic         done_q, done_d;

    // Next count and its zero flag
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        done_d = (count_d == {W{1'b0}});
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {W{1'b0}};
            done_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/ghostbus_host.sv
// Ghostbus master: turns a request stream into single writes and incrementing
// block reads, returning read beats on a response stream. Define
// GHOSTBUS_HOST_TIMEOUT_EN to add the rsp_err response-stall timeout.
module ghostbus_host
    import ghostbus_pkg::*;
#(
    parameter int AW     = GB_AW,
    parameter int DW     = GB_DW,
    parameter int RD_LAT = 1,
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
    parameter int TO_CYC = 255,
`endif
    parameter int LW     = 8
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          busy,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
    output logic          rsp_err,
`endif
    input  logic [DW-1:0] gb_din
);

`ifdef GHOSTBUS_HOST_TIMEOUT_EN
    localparam int TW = (TO_CYC > RD_LAT_MAX) ? $clog2(TO_CYC + 1) : 4;
    localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYC - 1);
`else
    localparam int TW = 4;
`endif
    // The timer holds cycles still to wait after the current one
    localparam logic [TW-1:0] LAT_LOAD = TW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] beats_q, beats_d;
    logic [AW-1:0] gb_addr_q, gb_addr_d;
    logic [DW-1:0] gb_dout_q, gb_dout_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          gb_we_q, gb_we_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_last_q, rsp_last_d;
    logic          busy_q, busy_d;
    logic          rsp_err_q, rsp_err_d;
    logic          req_fire_s, take_s;
    logic          timer_load_s, timer_dec_s, timer_done_s;
    logic [TW-1:0] timer_val_s;

    assign req_fire_s = req_valid & req_ready_q;

    // Transaction sequencing and next values of every registered output
    always_comb begin
        state_d      = state_q;
        beats_d      = beats_q;
        gb_addr_d    = gb_addr_q;
        gb_dout_d    = gb_dout_q;
        rsp_data_d   = rsp_data_q;
        rsp_last_d   = rsp_last_q;
        rsp_err_d    = 1'b0;
        take_s       = 1'b0;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        timer_val_s  = {TW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (req_fire_s) begin
                    gb_addr_d = req_addr;
                    if (req_we) begin
                        gb_dout_d = req_wdata;
                        state_d   = ST_WR;
                    end else begin
                        beats_d = req_len;
                        state_d = ST_RD_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD_ADDR: begin
                if (RD_LAT == 0) begin
                    take_s = 1'b1;
                end else begin
                    timer_load_s = 1'b1;
                    timer_val_s  = LAT_LOAD;
                    state_d      = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (timer_done_s) begin
                    take_s = 1'b1;
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    if (beats_q == {LW{1'b0}}) begin
                        state_d = ST_IDLE;
                    end else begin
                        gb_addr_d = gb_addr_q + {{(AW-1){1'b0}}, 1'b1};
                        beats_d   = beats_q - {{(LW-1){1'b0}}, 1'b1};
                        state_d   = ST_RD_ADDR;
                    end
                end else begin
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
                    if (timer_done_s) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        timer_dec_s = 1'b1;
                    end
`else
                    state_d = ST_RSP;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture the beat and arm the stall timer on the way into RSP
        if (take_s) begin
            rsp_data_d = gb_din;
            rsp_last_d = (beats_q == {LW{1'b0}});
            state_d    = ST_RSP;
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
            timer_load_s = 1'b1;
            timer_val_s  = TO_LOAD;
`endif
        end else begin
            rsp_data_d = rsp_data_q;
        end

        gb_we_d     = (state_d == ST_WR);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction at once
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            state_q     <= ST_IDLE;
            beats_q     <= {LW{1'b0}};
            gb_addr_q   <= {AW{1'b0}};
            gb_dout_q   <= {DW{1'b0}};
            rsp_data_q  <= {DW{1'b0}};
            gb_we_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            gb_addr_q   <= gb_addr_d;
            gb_dout_q   <= gb_dout_d;
            rsp_data_q  <= rsp_data_d;
            gb_we_q     <= gb_we_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            busy_q      <= busy_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    ghostbus_rd_timer #(
        .W(TW)
    ) u_timer (
        .clk      (gb_clk),
        .rst      (gb_rst),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .dec      (timer_dec_s),
        .done     (timer_done_s)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = busy_q;
    assign gb_addr   = gb_addr_q;
    assign gb_dout   = gb_dout_q;
    assign gb_we     = gb_we_q;
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    logic unused_s;
    assign unused_s = rsp_err_q | rsp_err_d;
`endif

endmodule

// File: tb/tb_ghostbus_host.sv
// Directed bench for ghostbus_host with a one-cycle-latency responder that
// returns {20'h0, gb_addr}; the timeout case runs when GHOSTBUS_HOST_TIMEOUT_EN is set.
module tb_ghostbus_host;

    logic        clk = 1'b0;
    logic        gb_rst;
    logic        req_valid, req_ready, req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  req_len;
    logic        rsp_valid, rsp_ready, rsp_last, busy;
    logic [31:0] rsp_data;
    logic [11:0] gb_addr;
    logic [31:0] gb_dout, gb_din;
    logic        gb_we;
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
    logic        rsp_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Responder: data valid one cycle after the address is presented
    always @(posedge clk) gb_din <= {20'h0, gb_addr};

    ghostbus_host #(
        .AW(12), .DW(32), .RD_LAT(1),
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
        .TO_CYC(10),
`endif
        .LW(8)
    ) dut (
        .gb_clk(clk), .gb_rst(gb_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy),
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we),
`ifdef GHOSTBUS_HOST_TIMEOUT_EN
        .rsp_err(rsp_err),
`endif
        .gb_din(gb_din)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic we, input logic [11:0] a, input logic [31:0] d, input logic [7:0] len);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_len = len;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(rsp_valid), 32'h1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        gb_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 12'h0;
        req_wdata = 32'h0; req_len = 8'h0; rsp_ready = 1'b0;
        step(); step();
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst gb_we",     32'(gb_we),     32'h0);
        chk("rst gb_addr",   32'(gb_addr),   32'h0);
        chk("rst busy",      32'(busy),      32'h0);
        gb_rst = 1'b0;
        step();
        chk("post-rst req_ready", 32'(req_ready), 32'h1);

        // Write, with a read request queued during WR that must stall
        start(1'b1, 12'h204, 32'hDEADBEEF, 8'h0);
        chk("wr gb_we",     32'(gb_we),     32'h1);
        chk("wr gb_addr",   32'(gb_addr),   32'h204);
        chk("wr gb_dout",   gb_dout,        32'hDEADBEEF);
        chk("wr req_ready", 32'(req_ready), 32'h0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h0AB; req_len = 8'h0;
        step();
        chk("wr done gb_we",     32'(gb_we),     32'h0);
        chk("wr done req_ready", 32'(req_ready), 32'h1);
        chk("wr addr hold",      32'(gb_addr),   32'h204);
        chk("wr no rsp",         32'(rsp_valid), 32'h0);
        step();
        req_valid = 1'b0;
        chk("stalled rd addr", 32'(gb_addr), 32'h0AB);
        wait_valid("stalled rd valid");
        chk("stalled rd data", rsp_data, 32'h0AB);
        accept();

        // Single read with exact latency
        start(1'b0, 12'h1FF, 32'h0, 8'h0);
        chk("rd1 lat0 valid", 32'(rsp_valid), 32'h0);
        step();
        chk("rd1 lat1 valid", 32'(rsp_valid), 32'h0);
        step();
        chk("rd1 valid", 32'(rsp_valid), 32'h1);
        chk("rd1 data",  rsp_data,        32'h000001FF);
        chk("rd1 last",  32'(rsp_last),  32'h1);
        accept();
        chk("rd1 drop valid", 32'(rsp_valid), 32'h0);
        chk("rd1 req_ready",  32'(req_ready), 32'h1);

        // Burst with back-pressure
        start(1'b0, 12'h3FE, 32'h0, 8'd3);
        for (int k = 0; k < 4; k++) begin
            wait_valid("burst valid");
            chk("burst data", rsp_data, 32'h3FE + 32'(k));
            chk("burst last", 32'(rsp_last), 32'(k == 3));
            for (int s = 0; s < (k % 2) + 1; s++) begin
                step();
                chk("burst hold valid", 32'(rsp_valid), 32'h1);
                chk("burst hold data",  rsp_data, 32'h3FE + 32'(k));
            end
            accept();
        end
        chk("burst end valid", 32'(rsp_valid), 32'h0);
        chk("burst end busy",  32'(busy),      32'h0);

        // Address wrap
        start(1'b0, 12'hFFF, 32'h0, 8'd1);
        wait_valid("wrap valid0");
        chk("wrap data0", rsp_data, 32'h00000FFF);
        chk("wrap last0", 32'(rsp_last), 32'h0);
        accept();
        wait_valid("wrap valid1");
        chk("wrap data1", rsp_data, 32'h00000000);
        chk("wrap last1", 32'(rsp_last), 32'h1);
        accept();

        // rsp_ready high while idle
        rsp_ready = 1'b1;
        step(); step();
        chk("idle rsp_ready valid", 32'(rsp_valid), 32'h0);
        chk("idle rsp_ready busy",  32'(busy),      32'h0);
        rsp_ready = 1'b0;

        // Reset during beat 2 of a len=7 burst
        start(1'b0, 12'h100, 32'h0, 8'd7);
        wait_valid("rst burst valid0");
        accept();
        wait_valid("rst burst valid1");
        gb_rst = 1'b1;
        #1;
        chk("async rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async rst busy",      32'(busy),      32'h0);
        step(); step();
        gb_rst = 1'b0;
        step();
        chk("rel req_ready", 32'(req_ready), 32'h1);
        chk("rel gb_we",     32'(gb_we),     32'h0);
        chk("rel rsp_valid", 32'(rsp_valid), 32'h0);
        start(1'b0, 12'h055, 32'h0, 8'h0);
        wait_valid("after rst valid");
        chk("after rst data", rsp_data, 32'h00000055);
        chk("after rst last", 32'(rsp_last), 32'h1);
        accept();

`ifdef GHOSTBUS_HOST_TIMEOUT_EN
        // Stalled response times out on wait cycle 11
        start(1'b0, 12'h010, 32'h0, 8'd2);
        wait_valid("to valid");
        for (int c = 2; c <= 10; c++) begin
            step();
            chk("to waiting valid", 32'(rsp_valid), 32'h1);
            chk("to waiting err",   32'(rsp_err),   32'h0);
        end
        step();
        chk("to err",       32'(rsp_err),   32'h1);
        chk("to valid off", 32'(rsp_valid), 32'h0);
        chk("to req_ready", 32'(req_ready), 32'h1);
        step();
        chk("to err pulse", 32'(rsp_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
